// File: rtl/qpsk_frame_writer.sv
// Buffers demapped 128-bit QPSK words in a small FIFO and writes one frame of a
// programmed length to memory through a valid/ready write port.
module qpsk_frame_writer #(
    parameter int DEPTH_LOG2 = 2,
    parameter int AW         = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic [AW-1:0]         base_addr,
    input  logic [AW-1:0]         frame_words,
    input  logic                  in_valid,
    input  logic [127:0]          in_data,
    output logic                  wr_en,
    output logic [AW-1:0]         wr_addr,
    output logic [127:0]          wr_data,
    input  logic                  wr_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [DEPTH_LOG2:0]   level
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                 state_q, state_d;
    logic                   in_valid_d_q;
    logic [AW-1:0]          cnt_q, cnt_d;
    logic [AW-1:0]          frame_words_q, frame_words_d;
    logic [AW-1:0]          next_addr_q, next_addr_d;
    logic                   overflow_q, overflow_d;
    logic [DEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]    level_q, level_d;
    logic                   wr_en_q, wr_en_d;
    logic [AW-1:0]          wr_addr_q, wr_addr_d;
    logic [127:0]           wr_data_q, wr_data_d;
    logic [127:0]           fifo_mem [DEPTH];

    logic                   in_edge;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   load;

    assign in_edge    = in_valid & ~in_valid_d_q;
    assign fifo_full  = (level_q == (DEPTH_LOG2+1)'(DEPTH));
    assign fifo_empty = (level_q == '0);
    // Full is judged on the current level only; a same-cycle pop does not make room.
    assign push       = (state_q == RUN) && in_edge && !fifo_full;
    assign load       = !fifo_empty && (!wr_en_q || wr_ready);

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        frame_words_d = frame_words_q;
        next_addr_d   = next_addr_q;
        overflow_d    = overflow_q;
        wr_en_d       = wr_en_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        level_d       = level_q + (DEPTH_LOG2+1)'(push) - (DEPTH_LOG2+1)'(load);

        case (state_q)
            IDLE: begin
                if (start) begin
                    frame_words_d = frame_words;
                    cnt_d         = '0;
                    next_addr_d   = base_addr;
                    overflow_d    = 1'b0;
                    state_d       = (frame_words == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_edge) begin
                    cnt_d = cnt_q + AW'(1);
                    if (fifo_full) begin
                        overflow_d = 1'b1;
                    end
                    if (cnt_q + AW'(1) == frame_words_q) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_empty && !wr_en_q) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
        end

        // Dropped words never reach the FIFO, so they consume no address.
        if (load) begin
            wr_en_d     = 1'b1;
            wr_data_d   = fifo_mem[rd_ptr_q];
            wr_addr_d   = next_addr_q;
            next_addr_d = next_addr_q + AW'(1);
            rd_ptr_d    = rd_ptr_q + DEPTH_LOG2'(1);
        end else if (wr_en_q && wr_ready) begin
            wr_en_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q       <= IDLE;
            in_valid_d_q  <= 1'b0;
            cnt_q         <= '0;
            frame_words_q <= '0;
            next_addr_q   <= '0;
            overflow_q    <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            level_q       <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
        end else begin
            state_q       <= state_d;
            in_valid_d_q  <= in_valid;
            cnt_q         <= cnt_d;
            frame_words_q <= frame_words_d;
            next_addr_q   <= next_addr_d;
            overflow_q    <= overflow_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            level_q       <= level_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= in_data;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = (state_q == RUN) || (state_q == DRAIN);
    assign done     = (state_q == DONE);
    assign overflow = overflow_q;
    assign level    = level_q;

endmodule

// File: tb/tb_qpsk_frame_writer.sv
// Self-checking bench for qpsk_frame_writer: frame vectors from a table, a write
// scoreboard fed at stimulus time, and directed overflow and reset sequences.
module tb_qpsk_frame_writer;

    logic         CLK;
    logic         RST;
    logic         start;
    logic [15:0]  base_addr;
    logic [15:0]  frame_words;
    logic         in_valid;
    logic [127:0] in_data;
    logic         wr_en;
    logic [15:0]  wr_addr;
    logic [127:0] wr_data;
    logic         wr_ready;
    logic         busy;
    logic         done;
    logic         overflow;
    logic [2:0]   level;

    typedef struct {
        logic [15:0]  addr;
        logic [127:0] data;
    } exp_t;

    typedef struct {
        logic [15:0] base;
        logic [15:0] frame;
        int          hold;
        int          gap;
        bit          toggle;
        bit          chk_lat;
    } vec_t;

    exp_t         exp_q[$];
    vec_t         vecs[6];
    int           assert_count = 0;
    int           fail_count   = 0;
    int           done_count   = 0;
    bit           toggle_ready = 0;
    bit           prev_stall   = 0;
    logic [15:0]  prev_addr;
    logic [127:0] prev_data;

    qpsk_frame_writer #(.DEPTH_LOG2(2), .AW(16)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .start       (start),
        .base_addr   (base_addr),
        .frame_words (frame_words),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .busy        (busy),
        .done        (done),
        .overflow    (overflow),
        .level       (level)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        assert_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge CLK);
        #1;
        if (toggle_ready) wr_ready = ~wr_ready;
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard side: every accepted transfer must match the oldest expected word,
    // and a stalled transfer must keep its address and data.
    always @(negedge CLK) begin
        if (!RST) begin
            prev_stall = 0;
        end else begin
            if (done) done_count++;
            if (prev_stall) begin
                checkOutput("stall_addr_stable", wr_addr, prev_addr);
                checkOutput("stall_data_stable", wr_data, prev_data);
            end
            if (wr_en && wr_ready) begin
                if (exp_q.size() == 0) begin
                    assert_count++;
                    fail_count++;
                    $display("[TB] FAIL unexpected_write actual=%h required=none", wr_addr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("wr_addr", wr_addr, e.addr);
                    checkOutput("wr_data", wr_data, e.data);
                end
            end
            prev_stall = wr_en && !wr_ready;
            prev_addr  = wr_addr;
            prev_data  = wr_data;
        end
    end

    task automatic startFrame(input logic [15:0] base, input logic [15:0] frame);
        stepCycle();
        base_addr   = base;
        frame_words = frame;
        start       = 1'b1;
        stepCycle();
        start = 1'b0;
    endtask

    task automatic waitDone(input int d0, input string name);
        int n;
        n = 0;
        while (done_count == d0 && n < 400) begin
            stepCycle();
            n++;
        end
        if (done_count == d0) begin
            assert_count++;
            fail_count++;
            $display("[TB] FAIL %s_timeout actual=no_done required=done", name);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        int           d0;
        logic [127:0] dat;
        logic [15:0]  a;
        d0           = done_count;
        toggle_ready = v.toggle;
        wr_ready     = 1'b1;
        startFrame(v.base, v.frame);
        @(negedge CLK);
        checkOutput("busy_after_start", busy, (v.frame != 0));
        for (int w = 0; w < v.frame; w++) begin
            stepCycle();
            dat      = rand128();
            in_data  = dat;
            in_valid = 1'b1;
            a        = v.base + 16'(w);
            exp_q.push_back('{a, dat});
            if (v.chk_lat) begin
                @(negedge CLK);
                checkOutput("lat_c0_wr_en", wr_en, 0);
                stepCycle();
                in_valid = 1'b0;
                in_data  = rand128();
                @(negedge CLK);
                checkOutput("lat_c1_wr_en", wr_en, 0);
                checkOutput("lat_c1_level", level, 1);
                stepCycle();
                @(negedge CLK);
                checkOutput("lat_c2_wr_en", wr_en, 1);
                checkOutput("lat_c2_wr_addr", wr_addr, a);
            end else begin
                for (int h = 1; h < v.hold; h++) begin
                    stepCycle();
                    in_data = rand128();
                end
                stepCycle();
                in_valid = 1'b0;
                in_data  = rand128();
            end
            for (int g = 1; g < v.gap; g++) stepCycle();
        end
        waitDone(d0, "frame_done");
        repeat (3) stepCycle();
        @(negedge CLK);
        checkOutput("done_pulses", done_count - d0, 1);
        checkOutput("busy_after_done", busy, 0);
        checkOutput("wr_en_after_done", wr_en, 0);
        checkOutput("level_after_done", level, 0);
        checkOutput("overflow_clean", overflow, 0);
        checkOutput("pending_writes", exp_q.size(), 0);
        toggle_ready = 0;
        wr_ready     = 1'b1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wr_en"}, wr_en, 0);
        checkOutput({tag, "_wr_addr"}, wr_addr, 0);
        checkOutput({tag, "_wr_data"}, wr_data, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_done"}, done, 0);
        checkOutput({tag, "_overflow"}, overflow, 0);
        checkOutput({tag, "_level"}, level, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int           d0;
        logic [127:0] dat;
        vec_t         zero_vec;

        vecs[0] = '{16'h0100, 16'd3, 1, 70, 1'b0, 1'b1};
        vecs[1] = '{16'h0400, 16'd2, 10, 4, 1'b0, 1'b0};
        vecs[2] = '{16'h0010, 16'd0, 1, 1, 1'b0, 1'b0};
        vecs[3] = '{16'h0500, 16'd4, 1, 3, 1'b1, 1'b0};
        vecs[4] = '{16'hFFFE, 16'd3, 2, 2, 1'b0, 1'b0};
        vecs[5] = '{16'h0020, 16'd4, 1, 1, 1'b0, 1'b0};

        RST         = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        frame_words = '0;
        in_valid    = 1'b0;
        in_data     = '0;
        wr_ready    = 1'b1;
        repeat (2) @(negedge CLK);
        checkAllZero("reset");
        stepCycle();
        RST = 1'b1;

        for (int i = 0; i < 6; i++) begin
            $display("[TB] vector %0d base=%h frame=%0d", i, vecs[i].base, vecs[i].frame);
            applyStimulus(vecs[i]);
        end

        // Overflow: first word parks in the stalled output register, four fill the FIFO, sixth is dropped.
        $display("[TB] overflow sequence");
        d0       = done_count;
        wr_ready = 1'b0;
        startFrame(16'h0200, 16'd6);
        for (int w = 0; w < 6; w++) begin
            stepCycle();
            dat      = rand128();
            in_data  = dat;
            in_valid = 1'b1;
            if (w < 5) exp_q.push_back('{16'h0200 + 16'(w), dat});
            stepCycle();
            in_valid = 1'b0;
        end
        @(negedge CLK);
        checkOutput("ovf_level", level, 4);
        checkOutput("ovf_flag", overflow, 1);
        checkOutput("ovf_wr_en", wr_en, 1);
        checkOutput("ovf_busy", busy, 1);
        stepCycle();
        base_addr   = 16'h7000;
        frame_words = 16'd1;
        start       = 1'b1;
        stepCycle();
        start    = 1'b0;
        wr_ready = 1'b1;
        waitDone(d0, "ovf_done");
        repeat (2) stepCycle();
        @(negedge CLK);
        checkOutput("ovf_sticky", overflow, 1);
        checkOutput("ovf_pending", exp_q.size(), 0);
        checkOutput("ovf_done_pulses", done_count - d0, 1);
        zero_vec = vecs[2];
        applyStimulus(zero_vec);

        // Asynchronous reset while a write is stalled in the drain phase.
        $display("[TB] reset-in-drain sequence");
        wr_ready = 1'b0;
        startFrame(16'h0300, 16'd2);
        for (int w = 0; w < 2; w++) begin
            stepCycle();
            dat      = rand128();
            in_data  = dat;
            in_valid = 1'b1;
            exp_q.push_back('{16'h0300 + 16'(w), dat});
            stepCycle();
            in_valid = 1'b0;
        end
        repeat (2) stepCycle();
        @(negedge CLK);
        checkOutput("drain_wr_en", wr_en, 1);
        checkOutput("drain_busy", busy, 1);
        #2;
        RST = 1'b0;
        #1;
        checkAllZero("async_reset");
        exp_q.delete();
        repeat (2) stepCycle();
        RST      = 1'b1;
        wr_ready = 1'b1;
        applyStimulus(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
